// File: rtl/arb_pkg.sv
// Shared types and default widths for the unified instruction/data memory arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_I,
        OWN_D,
        OWN_L
    } owner_t;

    localparam int ARB_ADDR_WIDTH = 8;
    localparam int ARB_DATA_WIDTH = 16;
    // Wide enough for the largest supported STARVE_LIMIT (15).
    localparam int STARVE_CNT_W   = 4;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating fetch-denial counter; at_limit_o forces fetch to win the next contention.
// Latency: registered count, at_limit_o is combinational from the count register.
// Backpressure: none; hold_i freezes the count, clr_i beats inc_i.
module arb_starve_cnt
    import arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  logic clr_i,
    input  logic hold_i,
    output logic at_limit_o
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

    logic [STARVE_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!hold_i) begin
            if (clr_i) begin
                cnt_d = '0;
            end else if (inc_i && (cnt_q != LIMIT)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit_o = (cnt_q == LIMIT);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port SRAM between fetch and data ports; data has priority, a starvation counter rescues fetch.
// Latency: grant is combinational in cycle N, read data and rvalid appear in cycle N+1 for one cycle.
// Backpressure: a request without grant must be held; the core stalls on it. ARB_LOADER_EN adds a top-priority loader write port.
module unified_mem_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = ARB_ADDR_WIDTH,
    parameter int DATA_WIDTH   = ARB_DATA_WIDTH,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  im_rd,
    input  logic [ADDR_WIDTH-1:0] im_addr,
    output logic                  im_gnt,
    output logic                  im_rvalid,
    output logic [DATA_WIDTH-1:0] im_r_data,
    input  logic                  dm_rd,
    input  logic                  dm_wr,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0] dm_w_data,
    output logic                  dm_gnt,
    output logic                  dm_rvalid,
    output logic [DATA_WIDTH-1:0] dm_r_data,
`ifdef ARB_LOADER_EN
    input  logic                  ld_wr,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_data,
    output logic                  ld_gnt,
`endif
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_w_data,
    input  logic [DATA_WIDTH-1:0] mem_r_data
);

    owner_t                  resp_owner_q, resp_owner_d;
    logic                    at_limit;
    logic                    dm_req;
    logic                    ld_g;
    logic                    core_ok;
    logic [ADDR_WIDTH-1:0]   ld_a;
    logic [DATA_WIDTH-1:0]   ld_d;

`ifdef ARB_LOADER_EN
    assign ld_g    = ~rst & ld_wr;
    assign core_ok = ~ld_wr;
    assign ld_a    = ld_addr;
    assign ld_d    = ld_data;
    assign ld_gnt  = ld_g;
`else
    assign ld_g    = 1'b0;
    assign core_ok = 1'b1;
    assign ld_a    = '0;
    assign ld_d    = '0;
`endif

    assign dm_req = dm_rd | dm_wr;

    always_comb begin
        im_gnt = 1'b0;
        dm_gnt = 1'b0;
        if (!rst && core_ok) begin
            if (at_limit && im_rd) begin
                im_gnt = 1'b1;
            end else if (dm_req) begin
                dm_gnt = 1'b1;
            end else if (im_rd) begin
                im_gnt = 1'b1;
            end
        end
    end

    // A combined dm_rd/dm_wr request is a write and never produces read data.
    always_comb begin
        mem_en     = ld_g | im_gnt | dm_gnt;
        mem_we     = ld_g | (dm_gnt & dm_wr);
        mem_addr   = '0;
        mem_w_data = '0;
        if (ld_g) begin
            mem_addr   = ld_a;
            mem_w_data = ld_d;
        end else if (dm_gnt) begin
            mem_addr = dm_addr;
            if (dm_wr) begin
                mem_w_data = dm_w_data;
            end
        end else if (im_gnt) begin
            mem_addr = im_addr;
        end
    end

    always_comb begin
        resp_owner_d = OWN_NONE;
        if (im_gnt) begin
            resp_owner_d = OWN_I;
        end else if (dm_gnt && !dm_wr) begin
            resp_owner_d = OWN_D;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_owner_q <= OWN_NONE;
        end else begin
            resp_owner_q <= resp_owner_d;
        end
    end

    // Gating on rst drops a read that was in flight when reset arrived.
    assign im_rvalid = ~rst & (resp_owner_q == OWN_I);
    assign dm_rvalid = ~rst & (resp_owner_q == OWN_D);
    assign im_r_data = im_rvalid ? mem_r_data : '0;
    assign dm_r_data = dm_rvalid ? mem_r_data : '0;

    arb_starve_cnt #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve_cnt (
        .clk        (clk),
        .rst        (rst),
        .inc_i      (im_rd & ~im_gnt),
        .clr_i      (im_gnt | ~im_rd),
        .hold_i     (ld_g),
        .at_limit_o (at_limit)
    );

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: directed scenarios plus a randomized run against a reference model.
module tb_unified_mem_arbiter;

    localparam int AW  = 8;
    localparam int DW  = 16;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          im_rd, im_gnt, im_rvalid;
    logic [AW-1:0] im_addr;
    logic [DW-1:0] im_r_data;
    logic          dm_rd, dm_wr, dm_gnt, dm_rvalid;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_w_data, dm_r_data;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_w_data;
    logic [DW-1:0] mem_r_data = '0;
`ifdef ARB_LOADER_EN
    logic          ld_wr, ld_gnt;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
`endif

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] sram    [256];
    logic [DW-1:0] ref_mem [256];

    unified_mem_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIM)
    ) dut (
        .clk(clk), .rst(rst),
        .im_rd(im_rd), .im_addr(im_addr), .im_gnt(im_gnt),
        .im_rvalid(im_rvalid), .im_r_data(im_r_data),
        .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_w_data(dm_w_data),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_r_data(dm_r_data),
`ifdef ARB_LOADER_EN
        .ld_wr(ld_wr), .ld_addr(ld_addr), .ld_data(ld_data), .ld_gnt(ld_gnt),
`endif
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_w_data(mem_w_data), .mem_r_data(mem_r_data)
    );

    always #5 clk = ~clk;

    // Single-port synchronous SRAM: read data valid the cycle after a read enable.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) sram[mem_addr] = mem_w_data;
            else        mem_r_data <= sram[mem_addr];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        im_rd = 1'b0; im_addr = '0;
        dm_rd = 1'b0; dm_wr = 1'b0; dm_addr = '0; dm_w_data = '0;
`ifdef ARB_LOADER_EN
        ld_wr = 1'b0; ld_addr = '0; ld_data = '0;
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        im_rd = 1'b1; im_addr = 8'h33; dm_rd = 1'b1; dm_addr = 8'h44;
        next_cycle();
        next_cycle();
        @(negedge clk);
        tests++; if ({im_gnt, dm_gnt, im_rvalid, dm_rvalid, mem_en, mem_we} !== 6'b0) begin
            fails++; $display("FAIL reset_ctrl: got %b want 000000", {im_gnt, dm_gnt, im_rvalid, dm_rvalid, mem_en, mem_we});
        end
        tests++; if (mem_addr !== 8'h00) begin fails++; $display("FAIL reset_mem_addr: got %h want 00", mem_addr); end
        tests++; if (mem_w_data !== 16'h0000) begin fails++; $display("FAIL reset_mem_w_data: got %h want 0000", mem_w_data); end
        tests++; if ({im_r_data, dm_r_data} !== 32'h0) begin
            fails++; $display("FAIL reset_r_data: got %h/%h want 0000/0000", im_r_data, dm_r_data);
        end
`ifdef ARB_LOADER_EN
        tests++; if (ld_gnt !== 1'b0) begin fails++; $display("FAIL reset_ld_gnt: got %b want 0", ld_gnt); end
`endif
        next_cycle();
        rst = 1'b0;
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_fetch_only();
        sram[5] = 16'hA1B2; ref_mem[5] = 16'hA1B2;
        im_rd = 1'b1; im_addr = 8'h05;
        @(negedge clk);
        tests++; if ({im_gnt, dm_gnt} !== 2'b10) begin fails++; $display("FAIL fetch_gnt: got im/dm %b want 10", {im_gnt, dm_gnt}); end
        tests++; if ({mem_en, mem_we} !== 2'b10) begin fails++; $display("FAIL fetch_en_we: got %b want 10", {mem_en, mem_we}); end
        tests++; if (mem_addr !== 8'h05) begin fails++; $display("FAIL fetch_addr: got %h want 05", mem_addr); end
        next_cycle();
        im_rd = 1'b0;
        @(negedge clk);
        tests++; if ({im_rvalid, dm_rvalid} !== 2'b10) begin fails++; $display("FAIL fetch_rvalid: got %b want 10", {im_rvalid, dm_rvalid}); end
        tests++; if (im_r_data !== 16'hA1B2) begin fails++; $display("FAIL fetch_data: got %h want a1b2", im_r_data); end
        next_cycle();
        @(negedge clk);
        tests++; if (im_rvalid !== 1'b0) begin fails++; $display("FAIL fetch_rvalid_once: got %b want 0", im_rvalid); end
        next_cycle();
    endtask

    task automatic test_write_read();
        dm_wr = 1'b1; dm_addr = 8'h10; dm_w_data = 16'h1234;
        @(negedge clk);
        tests++; if ({dm_gnt, mem_we} !== 2'b11) begin fails++; $display("FAIL wr_gnt_we: got %b want 11", {dm_gnt, mem_we}); end
        tests++; if ({mem_addr, mem_w_data} !== {8'h10, 16'h1234}) begin
            fails++; $display("FAIL wr_bus: got %h/%h want 10/1234", mem_addr, mem_w_data);
        end
        ref_mem[8'h10] = 16'h1234;
        next_cycle();
        dm_wr = 1'b0; dm_rd = 1'b1;
        @(negedge clk);
        tests++; if ({dm_gnt, mem_we, dm_rvalid} !== 3'b100) begin
            fails++; $display("FAIL rd_after_wr: got gnt/we/rvalid %b want 100", {dm_gnt, mem_we, dm_rvalid});
        end
        next_cycle();
        dm_rd = 1'b0;
        @(negedge clk);
        tests++; if (dm_rvalid !== 1'b1 || dm_r_data !== 16'h1234) begin
            fails++; $display("FAIL rd_data: got rvalid %b data %h want 1 1234", dm_rvalid, dm_r_data);
        end
        next_cycle();
    endtask

    task automatic test_rd_wr_both();
        dm_rd = 1'b1; dm_wr = 1'b1; dm_addr = 8'h20; dm_w_data = 16'hBEEF;
        @(negedge clk);
        tests++; if ({dm_gnt, mem_en, mem_we} !== 3'b111) begin
            fails++; $display("FAIL both_we: got %b want 111", {dm_gnt, mem_en, mem_we});
        end
        ref_mem[8'h20] = 16'hBEEF;
        next_cycle();
        dm_rd = 1'b0; dm_wr = 1'b0;
        @(negedge clk);
        tests++; if (dm_rvalid !== 1'b0) begin fails++; $display("FAIL both_no_rvalid: got %b want 0", dm_rvalid); end
        next_cycle();
        dm_rd = 1'b1;
        next_cycle();
        dm_rd = 1'b0;
        @(negedge clk);
        tests++; if (dm_rvalid !== 1'b1 || dm_r_data !== 16'hBEEF) begin
            fails++; $display("FAIL both_readback: got rvalid %b data %h want 1 beef", dm_rvalid, dm_r_data);
        end
        next_cycle();
    endtask

    task automatic test_starvation();
        im_rd = 1'b1; im_addr = 8'h05; dm_rd = 1'b1; dm_addr = 8'h10;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            tests++; if ({im_gnt, dm_gnt} !== {k % 5 == 4, k % 5 != 4}) begin
                fails++; $display("FAIL starve_gnt[%0d]: got im/dm %b want %b", k, {im_gnt, dm_gnt}, {k % 5 == 4, k % 5 != 4});
            end
            if (k > 0) begin
                tests++; if ({im_rvalid, dm_rvalid} !== {(k - 1) % 5 == 4, (k - 1) % 5 != 4}) begin
                    fails++; $display("FAIL starve_rvalid[%0d]: got %b", k, {im_rvalid, dm_rvalid});
                end
            end
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_reset_mid_read();
        im_rd = 1'b1; im_addr = 8'h05;
        @(negedge clk);
        tests++; if (im_gnt !== 1'b1) begin fails++; $display("FAIL midrst_gnt: got %b want 1", im_gnt); end
        next_cycle();
        rst = 1'b1; dm_rd = 1'b1; dm_addr = 8'h10;
        @(negedge clk);
        tests++; if ({im_rvalid, dm_rvalid, im_gnt, dm_gnt, mem_en, mem_we} !== 6'b0 || im_r_data !== 16'h0) begin
            fails++; $display("FAIL midrst_outputs: got %b data %h want 000000 0000",
                              {im_rvalid, dm_rvalid, im_gnt, dm_gnt, mem_en, mem_we}, im_r_data);
        end
        next_cycle();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            tests++; if (im_gnt !== (k == 4)) begin
                fails++; $display("FAIL midrst_cnt[%0d]: got im_gnt %b want %b", k, im_gnt, k == 4);
            end
            next_cycle();
        end
        idle_inputs();
        next_cycle();
        next_cycle();
    endtask

`ifdef ARB_LOADER_EN
    task automatic test_loader();
        im_rd = 1'b1; im_addr = 8'h05; dm_rd = 1'b1; dm_addr = 8'h10;
        next_cycle();
        next_cycle();
        dm_rd = 1'b0; dm_wr = 1'b1; dm_addr = 8'h31; dm_w_data = 16'h0F0F;
        ld_wr = 1'b1; ld_addr = 8'h30; ld_data = 16'h5A5A;
        @(negedge clk);
        tests++; if ({ld_gnt, im_gnt, dm_gnt, mem_we} !== 4'b1001) begin
            fails++; $display("FAIL ld_gnt: got ld/im/dm/we %b want 1001", {ld_gnt, im_gnt, dm_gnt, mem_we});
        end
        tests++; if ({mem_addr, mem_w_data} !== {8'h30, 16'h5A5A}) begin
            fails++; $display("FAIL ld_bus: got %h/%h want 30/5a5a", mem_addr, mem_w_data);
        end
        ref_mem[8'h30] = 16'h5A5A;
        next_cycle();
        ld_wr = 1'b0;
        @(negedge clk);
        tests++; if ({im_gnt, dm_gnt} !== 2'b01) begin fails++; $display("FAIL ld_after_wr: got %b want 01", {im_gnt, dm_gnt}); end
        ref_mem[8'h31] = 16'h0F0F;
        next_cycle();
        dm_wr = 1'b0; dm_rd = 1'b1; dm_addr = 8'h30;
        @(negedge clk);
        tests++; if ({im_gnt, dm_gnt} !== 2'b01) begin fails++; $display("FAIL ld_after_rd: got %b want 01", {im_gnt, dm_gnt}); end
        next_cycle();
        @(negedge clk);
        tests++; if ({im_gnt, dm_gnt} !== 2'b10) begin fails++; $display("FAIL ld_cnt_held: got %b want 10", {im_gnt, dm_gnt}); end
        tests++; if (dm_rvalid !== 1'b1 || dm_r_data !== 16'h5A5A) begin
            fails++; $display("FAIL ld_readback: got %b %h want 1 5a5a", dm_rvalid, dm_r_data);
        end
        next_cycle();
        idle_inputs();
        next_cycle();
        next_cycle();
    endtask
`endif

    task automatic test_random();
        int            cnt  = 0;
        int            pend = 0;
        logic [DW-1:0] pend_d = '0;
        logic          eig, edg, ewe;
        logic [1:0]    r;
        idle_inputs();
        next_cycle();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            eig = im_rd && (cnt == LIM || !(dm_rd || dm_wr));
            edg = (dm_rd || dm_wr) && !eig;
            ewe = edg && dm_wr;
            tests++; if ({im_gnt, dm_gnt, mem_en, mem_we} !== {eig, edg, eig | edg, ewe}) begin
                fails++; $display("FAIL rnd_gnt[%0d]: got im/dm/en/we %b want %b", c,
                                  {im_gnt, dm_gnt, mem_en, mem_we}, {eig, edg, eig | edg, ewe});
            end
            if (eig || edg) begin
                tests++; if (mem_addr !== (eig ? im_addr : dm_addr)) begin
                    fails++; $display("FAIL rnd_addr[%0d]: got %h want %h", c, mem_addr, eig ? im_addr : dm_addr);
                end
            end
            if (ewe) begin
                tests++; if (mem_w_data !== dm_w_data) begin
                    fails++; $display("FAIL rnd_wdata[%0d]: got %h want %h", c, mem_w_data, dm_w_data);
                end
            end
            tests++; if ({im_rvalid, dm_rvalid} !== {pend == 1, pend == 2}) begin
                fails++; $display("FAIL rnd_rvalid[%0d]: got %b want %b", c, {im_rvalid, dm_rvalid}, {pend == 1, pend == 2});
            end
            if (pend != 0) begin
                tests++; if ((pend == 1 ? im_r_data : dm_r_data) !== pend_d) begin
                    fails++; $display("FAIL rnd_rdata[%0d]: got %h want %h", c, pend == 1 ? im_r_data : dm_r_data, pend_d);
                end
            end
            if (eig) begin
                pend = 1; pend_d = ref_mem[im_addr];
            end else if (edg && !dm_wr) begin
                pend = 2; pend_d = ref_mem[dm_addr];
            end else begin
                pend = 0;
            end
            if (ewe) ref_mem[dm_addr] = dm_w_data;
            cnt = (eig || !im_rd) ? 0 : ((cnt < LIM) ? cnt + 1 : LIM);
            next_cycle();
            if (!(im_rd && !eig) || $urandom_range(9) == 0) begin
                im_rd   = ($urandom_range(9) < 6);
                im_addr = AW'($urandom);
            end
            if (!((dm_rd || dm_wr) && !edg)) begin
                r         = 2'($urandom);
                dm_rd     = r[0];
                dm_wr     = r[1];
                dm_addr   = AW'($urandom);
                dm_w_data = DW'($urandom);
            end
        end
        idle_inputs();
        next_cycle();
        next_cycle();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            sram[i]    = DW'($urandom);
            ref_mem[i] = sram[i];
        end
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_fetch_only();
        test_write_read();
        test_rd_wr_both();
        test_starvation();
        test_reset_mid_read();
`ifdef ARB_LOADER_EN
        test_loader();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
